// File: rtl/seq_multiplier_if.sv
// Handshake bundle between the execute-stage controller and seq_multiplier.
// The controller side uses the master modport; the multiplier uses slave.
interface seq_multiplier_if #(
  parameter int N = 32
);
  logic           start;
  logic           is_signed;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
    output start,
    output is_signed,
    output a,
    output b,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  is_signed,
    input  a,
    input  b,
    output busy,
    output done,
    output product
  );
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-and-add multiplier, N x N -> 2N bits.
// One conditional add plus one-bit right shift per cycle over N cycles.
// Optional signed support is compiled in with the SEQ_MUL_SIGNED_EN macro:
// operands are turned into magnitudes at start and a FIX state conditionally
// negates the product. FIX is always visited in that build so the latency
// does not depend on the operand signs.
module seq_multiplier #(
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              rst,
  seq_multiplier_if.slave   bus
);

  localparam int            CW        = $clog2(N);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

`ifdef SEQ_MUL_SIGNED_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  state_t         state_q, state_d;
  logic [2*N-1:0] p_q, p_d;       // product / shifting multiplier register
  logic [N-1:0]   m_q, m_d;       // multiplicand magnitude
  logic [CW-1:0]  cnt_q, cnt_d;   // step counter
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [N-1:0]   mag_a;
  logic [N-1:0]   mag_b;
  logic [N:0]     sum;

`ifdef SEQ_MUL_SIGNED_EN
  logic neg_q, neg_d;
  logic a_neg, b_neg;

  // Operand magnitudes; the most-negative value maps to itself, which is
  // exactly its magnitude when read as unsigned.
  always_comb begin
    a_neg = bus.is_signed & bus.a[N-1];
    b_neg = bus.is_signed & bus.b[N-1];
    mag_a = a_neg ? (~bus.a + N'(1)) : bus.a;
    mag_b = b_neg ? (~bus.b + N'(1)) : bus.b;
  end
`else
  // Unsigned-only build: the operands are used as-is and is_signed is ignored.
  logic unused_is_signed;
  assign unused_is_signed = bus.is_signed;
  assign mag_a = bus.a;
  assign mag_b = bus.b;
`endif

  // One step of the adder: upper half plus the multiplicand when the current
  // multiplier bit (P[0]) is set, keeping the carry out as bit N.
  assign sum = {1'b0, p_q[2*N-1:N]} + (p_q[0] ? {1'b0, m_q} : {(N+1){1'b0}});

  // Next-state and datapath control for IDLE -> RUN -> (FIX) -> DONE.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = mag_a;
          p_d     = {{N{1'b0}}, mag_b};
          cnt_d   = '0;
`ifdef SEQ_MUL_SIGNED_EN
          neg_d   = bus.is_signed & (bus.a[N-1] ^ bus.b[N-1]);
`endif
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Shift right by one with the adder carry landing in bit 2N-1.
        p_d   = {sum, p_q[N-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
`ifdef SEQ_MUL_SIGNED_EN
          state_d = FIX;
`else
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
`endif
        end
      end
`ifdef SEQ_MUL_SIGNED_EN
      FIX: begin
        // Restore the sign of the full 2N-bit result.
        p_d     = neg_q ? (~p_q + (2*N)'(1)) : p_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
`endif
      DONE: begin
        // A start seen here is dropped, not remembered.
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEQ_MUL_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: stimulus pushes expected products,
// a monitor pops them whenever done is seen and checks value and latency.
module tb_seq_multiplier;
  localparam int N = 32;
`ifdef SEQ_MUL_SIGNED_EN
  localparam int LAT = N + 2;
`else
  localparam int LAT = N + 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_multiplier_if #(.N(N)) bus ();

  seq_multiplier #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] prod;
    int          acc;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;
  exp_t        sb_q[$];
  logic [63:0] last_exp   = '0;
  bit          last_valid = 1'b0;

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: the mathematical product of the operands as integers.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic   use_signed;
    longint sa, sb;
    use_signed = s;
`ifndef SEQ_MUL_SIGNED_EN
    use_signed = 1'b0;
`endif
    if (use_signed) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.done) begin
        chkint("busy_with_done", int'(bus.busy), 0);
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got product %h expected no done", bus.product);
        end else begin
          e = sb_q.pop_front();
          chk64("product", bus.product, e.prod);
          chkint("latency", cyc - e.acc + 1, LAT);
          last_exp   = e.prod;
          last_valid = 1'b1;
          $display("[TB] a=%h b=%h product=%h expected=%h", e.a, e.b, bus.product, e.prod);
        end
      end
    end
  end

  task automatic wait_done();
    int i;
    for (i = 0; i < 200; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic wait_idle();
    wait_done();
    for (int i = 0; i < 4 && bus.done; i++) @(negedge clk);
    if (last_valid) chk64("product_hold", bus.product, last_exp);
  endtask

  // Issue one accepted request; returns at the negedge after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] exp);
    wait_idle();
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = s;
    bus.start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    sb_q.push_back('{exp, cyc, a, b});
    chkint("busy_after_start", int'(bus.busy), 1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = '0;
    bus.b         = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chkint("reset_busy", int'(bus.busy), 0);
    chkint("reset_done", int'(bus.done), 0);
    chk64("reset_product", bus.product, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    issue(32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
`ifdef SEQ_MUL_SIGNED_EN
    issue(32'hFFFF_FFF9, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
`else
    issue(32'hFFFF_FFF9, 32'd3, 1'b1, 64'h0000_0002_FFFF_FFEB);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
`endif

    // Start while busy is ignored
    issue(32'd1000, 32'd77, 1'b0, 64'd77000);
    repeat (9) @(negedge clk);
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chkint("busy_during_ignored_start", int'(bus.busy), 1);
    wait_done();
    repeat (40) @(negedge clk);

    // Start during DONE ignored, start in the following cycle accepted
    issue(32'd12, 32'd12, 1'b0, 64'd144);
    for (int i = 0; i < 200 && !bus.done; i++) @(negedge clk);
    bus.a     = 32'd6;
    bus.b     = 32'd7;
    bus.start = 1'b1;
    @(negedge clk);
    chkint("start_in_done_ignored", int'(bus.busy), 0);
    chk64("product_after_done", bus.product, 64'd144);
    @(negedge clk);
    bus.start = 1'b0;
    sb_q.push_back('{64'd42, cyc, 32'd6, 32'd7});
    chkint("back_to_back_busy", int'(bus.busy), 1);
    wait_done();

    // Reset in the middle of a run
    issue(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 64'h0);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    sb_q.delete();
    last_valid = 1'b0;
    chkint("midrun_reset_busy", int'(bus.busy), 0);
    chkint("midrun_reset_done", int'(bus.done), 0);
    chk64("midrun_reset_product", bus.product, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'd2, 32'd4, 1'b0, 64'd8);

    // Randomized traffic against the reference model
    for (int n = 0; n < 30; n++) begin
      ra = pick();
      rb = pick();
      rs = 1'($urandom_range(0, 1));
      issue(ra, rb, rs, model(ra, rb, rs));
    end
    wait_idle();
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential radix-2 shift-and-add multiplier for the 32-bit computer's ALU. It takes two N-bit operands on a start pulse and produces a 2N-bit product after a fixed number of cycles. Each step conditionally adds the multiplicand into the upper half of a 2N-bit product register, then applies a one-bit logical right shift: the same operation as the 64-bit single-bit right-shift stage, carry-in taking bit 63. It sits beside the ALU's combinational shifters and is handshaked by the execute-stage controller.

## Interface
- N, 32, operand width; product is 2N bits; step counter is clog2(N) bits
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- is_signed  input  1  operands are two's complement; honored only with SEQ_MUL_SIGNED_EN
- a  input  N  multiplicand, captured on accepted start
- b  input  N  multiplier, captured on accepted start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  single-cycle pulse when product is valid
- product  output  2N  result; held stable from done until the next accepted start

## Operation
- States: IDLE, RUN, FIX (present only with SEQ_MUL_SIGNED_EN), DONE.
- IDLE with start=1: capture operands; M <= |a| (or a); P <= {N'b0, |b| (or b)}; cnt <= 0; neg <= is_signed & (a[N-1] ^ b[N-1]); go to RUN.
- RUN, each cycle:
  - sum[N:0] = P[2N-1:N] + (P[0] ? M : 0), an (N+1)-bit add.
  - P <= {sum[N:0], P[N-1:1]}, i.e. a right shift with carry into bit 2N-1.
  - cnt++; after the step with cnt == N-1, go to FIX if present, else DONE.
- FIX: P <= neg ? (~P + 1) : P, a 2N-bit two's-complement negate; go to DONE.
- DONE: done=1 for exactly this cycle; go to IDLE.
- Magnitude of the most-negative operand (0x80000000) is 0x80000000 read as unsigned. This is correct because M and the lower half of P are treated as unsigned.
- start while busy, or in the DONE cycle, is ignored and not queued.
- product is driven from P. It changes only during RUN and FIX.
- rst at any time: state <= IDLE; P, M, cnt, neg <= 0; the operation in flight is discarded.

## Timing
- Reset values: busy=0, done=0, product=0.
- Accepted start at edge E0. busy=1 from E0 through the edge that enters DONE.
- RUN occupies N cycles, E0+1 … E0+N.
- Without the macro, done is high in cycle E0+N+1. Latency is N+1 = 33 cycles.
- With the macro, FIX is always taken, including for unsigned operations, so latency stays constant. done is high in cycle E0+N+2, giving 34 cycles.
- busy and done are never high together. Back-to-back: a start in the cycle after done is accepted.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- SEQ_MUL_SIGNED_EN defined:
  - is_signed is honored; operands are converted to magnitudes at start.
  - The FIX state is present and applies conditional negation.
- SEQ_MUL_SIGNED_EN undefined:
  - is_signed is ignored; all operations are unsigned.
  - The FIX state, the neg flag and the negation logic are absent.

## Test plan
- Basic unsigned: a=3, b=5 -> product=0x000000000000000F; done in the cycle 33 (34 with macro) after start.
- Unsigned max: a=b=0xFFFFFFFF, is_signed=0 -> product=0xFFFFFFFE00000001.
- Signed, with macro: a=0xFFFFFFF9 (-7), b=3 -> 0xFFFFFFFFFFFFFFEB; a=b=0x80000000 -> 0x4000000000000000; a=b=0xFFFFFFFF -> 0x0000000000000001.
- Signed request without macro: a=0xFFFFFFF9, b=3, is_signed=1 -> 0x00000002FFFFFFEB (unsigned result), latency 33.
- Start while busy: a second start with a=9, b=9 on cycle E0+10 -> ignored; the first result is unchanged. A start on the cycle after done is accepted; its busy rises on the next cycle.
- Reset mid-run: rst on cycle E0+15 -> busy=0, done=0, product=0 immediately, with no done pulse afterwards. A new start with a=2, b=4 then yields 8.
